// File: rtl/ejector_local.sv
// ejector_local: Local-port packet sink for a mesh node.
// Accepts packets through a Req/Gnt/Full handshake into a small FIFO, drains
// them at a programmable rate and scores per-source PacketID sequencing.
module ejector_local #(
   parameter logic [5:0] routerID    = 6'b000_000,
   parameter int         packetwidth = 56,
   parameter int         DEPTH       = 4,
   parameter int         DRAIN_DELAY = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ReqUpStr,
   input  logic [packetwidth-1:0] PacketIn,
   output logic                   GntUpStr,
   output logic                   UpStrFull,
   output logic                   EjectValid,
   output logic [packetwidth-1:0] EjectPacket,
   output logic [15:0]            RxCount,
   output logic [15:0]            SeqErrCount,
   output logic                   SeqErr,
   output logic [5:0]             LastSrcID,
   output logic [9:0]             LastPacketID
);

   localparam int          PW        = $clog2(DEPTH);
   localparam int          CW        = PW + 1;
   localparam logic [31:0] DRAIN_LIM = 32'(DRAIN_DELAY);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      RX_IDLE     = 2'd0,
      RX_GRANT    = 2'd1,
      RX_WAIT_REL = 2'd2
   } rx_state_t;

   rx_state_t               state_q, state_d;
   logic                    gnt_q, gnt_d;
   logic                    push_s, pop_s, err_s;
   logic [packetwidth-1:0]  mem_q [DEPTH];
   logic [PW-1:0]           head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    full_q, full_d;
   logic [31:0]             drain_q, drain_d;
   logic                    valid_q;
   logic [packetwidth-1:0]  pkt_q;
   logic [15:0]             rx_q, rx_d, errc_q, errc_d;
   logic                    sticky_q, sticky_d;
   logic [5:0]              lsrc_q;
   logic [9:0]              lpid_q;
   logic [9:0]              exp_q [64];
   logic [packetwidth-1:0]  head_pkt_s;
   logic [5:0]              src_s;
   logic [9:0]              pid_s;

   assign head_pkt_s = mem_q[head_q];
   assign src_s      = head_pkt_s[15:10];
   assign pid_s      = head_pkt_s[25:16];
   assign err_s      = (pid_s != exp_q[src_s]) || (src_s == routerID);

   // Receive handshake FSM: capture once per request, then wait for release.
   always_comb begin
      state_d = state_q;
      gnt_d   = 1'b0;
      push_s  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (ReqUpStr && !full_q) begin
               push_s  = 1'b1;
               gnt_d   = 1'b1;
               state_d = RX_GRANT;
            end else begin
               state_d = RX_IDLE;
            end
         end
         RX_GRANT:    state_d = RX_WAIT_REL;
         RX_WAIT_REL: begin
            if (!ReqUpStr) begin
               state_d = RX_IDLE;
            end else begin
               state_d = RX_WAIT_REL;
            end
         end
         default:     state_d = RX_IDLE;
      endcase
   end

   // Drain pacing: count up while occupied, pop when the delay is reached.
   always_comb begin
      pop_s   = 1'b0;
      drain_d = 32'd0;
      if (count_q == {CW{1'b0}}) begin
         drain_d = 32'd0;
      end else if (drain_q == DRAIN_LIM) begin
         pop_s   = 1'b1;
         drain_d = 32'd0;
      end else begin
         drain_d = drain_q + 32'd1;
      end
   end

   // FIFO pointer and occupancy bookkeeping; full mirrors the next occupancy.
   always_comb begin
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (push_s) begin
         tail_d = tail_q + PW'(1);
      end else begin
         tail_d = tail_q;
      end
      if (pop_s) begin
         head_d = head_q + PW'(1);
      end else begin
         head_d = head_q;
      end
      full_d = (count_d == FULL_CNT);
   end

   // Receive statistics with saturating counters and a sticky error flag.
   always_comb begin
      rx_d     = rx_q;
      errc_d   = errc_q;
      sticky_d = sticky_q;
      if (pop_s) begin
         if (rx_q != 16'hFFFF) begin
            rx_d = rx_q + 16'd1;
         end else begin
            rx_d = rx_q;
         end
         if (err_s) begin
            sticky_d = 1'b1;
            if (errc_q != 16'hFFFF) begin
               errc_d = errc_q + 16'd1;
            end else begin
               errc_d = errc_q;
            end
         end else begin
            errc_d = errc_q;
         end
      end else begin
         rx_d = rx_q;
      end
   end

   // Control, pointer and statistics registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= RX_IDLE;
         gnt_q    <= 1'b0;
         head_q   <= {PW{1'b0}};
         tail_q   <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
         full_q   <= 1'b0;
         drain_q  <= 32'd0;
         valid_q  <= 1'b0;
         pkt_q    <= {packetwidth{1'b0}};
         rx_q     <= 16'd0;
         errc_q   <= 16'd0;
         sticky_q <= 1'b0;
         lsrc_q   <= 6'd0;
         lpid_q   <= 10'd0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         full_q   <= full_d;
         drain_q  <= drain_d;
         valid_q  <= pop_s;
         rx_q     <= rx_d;
         errc_q   <= errc_d;
         sticky_q <= sticky_d;
         if (pop_s) begin
            pkt_q  <= head_pkt_s;
            lsrc_q <= src_s;
            lpid_q <= pid_s;
         end
      end
   end

   // FIFO storage and the per-source expected PacketID table.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {packetwidth{1'b0}};
         end
         for (int j = 0; j < 64; j++) begin
            exp_q[j] <= 10'd1;
         end
      end else begin
         if (push_s) begin
            mem_q[tail_q] <= PacketIn;
         end
         if (pop_s) begin
            exp_q[src_s] <= pid_s + 10'd1;
         end
      end
   end

   assign GntUpStr     = gnt_q;
   assign UpStrFull    = full_q;
   assign EjectValid   = valid_q;
   assign EjectPacket  = pkt_q;
   assign RxCount      = rx_q;
   assign SeqErrCount  = errc_q;
   assign SeqErr       = sticky_q;
   assign LastSrcID    = lsrc_q;
   assign LastPacketID = lpid_q;

endmodule

// File: tb/tb_ejector_local.sv
// Directed bench for ejector_local. Three instances cover the configurations
// needed: u0 (routerID 0, no drain delay), u1 (drain delay 200), u2 (routerID 16).
module tb_ejector_local;

   logic        clk = 1'b0;
   logic        reset;
   logic        req  [3];
   logic [55:0] pkt  [3];
   logic        gnt  [3];
   logic        full [3];
   logic        ev   [3];
   logic [55:0] epkt [3];
   logic [15:0] rxc  [3];
   logic [15:0] sec  [3];
   logic        se   [3];
   logic [5:0]  lsrc [3];
   logic [9:0]  lpid [3];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ejector_local #(.routerID(6'b000_000), .packetwidth(56), .DEPTH(4), .DRAIN_DELAY(0)) u0 (
      .clk(clk), .reset(reset), .ReqUpStr(req[0]), .PacketIn(pkt[0]),
      .GntUpStr(gnt[0]), .UpStrFull(full[0]), .EjectValid(ev[0]), .EjectPacket(epkt[0]),
      .RxCount(rxc[0]), .SeqErrCount(sec[0]), .SeqErr(se[0]),
      .LastSrcID(lsrc[0]), .LastPacketID(lpid[0]));

   ejector_local #(.routerID(6'b000_000), .packetwidth(56), .DEPTH(4), .DRAIN_DELAY(200)) u1 (
      .clk(clk), .reset(reset), .ReqUpStr(req[1]), .PacketIn(pkt[1]),
      .GntUpStr(gnt[1]), .UpStrFull(full[1]), .EjectValid(ev[1]), .EjectPacket(epkt[1]),
      .RxCount(rxc[1]), .SeqErrCount(sec[1]), .SeqErr(se[1]),
      .LastSrcID(lsrc[1]), .LastPacketID(lpid[1]));

   ejector_local #(.routerID(6'b010_000), .packetwidth(56), .DEPTH(4), .DRAIN_DELAY(0)) u2 (
      .clk(clk), .reset(reset), .ReqUpStr(req[2]), .PacketIn(pkt[2]),
      .GntUpStr(gnt[2]), .UpStrFull(full[2]), .EjectValid(ev[2]), .EjectPacket(epkt[2]),
      .RxCount(rxc[2]), .SeqErrCount(sec[2]), .SeqErr(se[2]),
      .LastSrcID(lsrc[2]), .LastPacketID(lpid[2]));

   function automatic logic [55:0] mk(input logic [5:0] src, input logic [9:0] pid,
                                      input logic [9:0] ri);
      return {30'd0, pid, src, ri};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Router-side send: raise Req, wait for Gnt, drop Req and hold it low
   // for the two edges the FSM needs to return to idle.
   task automatic send(input int k, input logic [55:0] p, output int cap);
      int n;
      cap    = -1;
      req[k] = 1'b1;
      pkt[k] = p;
      n      = 0;
      while (cap < 0 && n < 600) begin
         tick();
         if (gnt[k]) cap = cyc;
         n++;
      end
      req[k] = 1'b0;
      chk("send_grant_seen", 64'(cap >= 0), 64'd1);
      tick();
      tick();
   endtask

   initial begin
      int cap, cap1, cap5, gcnt, n;
      logic [55:0] p1;
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         req[k] = 1'b0;
         pkt[k] = 56'd0;
      end
      repeat (3) tick();
      chk("rst_gnt",   64'(gnt[0]),  64'd0);
      chk("rst_full",  64'(full[0]), 64'd0);
      chk("rst_ev",    64'(ev[0]),   64'd0);
      chk("rst_rxc",   64'(rxc[0]),  64'd0);
      chk("rst_sec",   64'(sec[0]),  64'd0);
      #2 reset = 1'b1;
      tick();

      // 1: single packet, grant one cycle, pop the following edge
      p1     = mk(6'd1, 10'd1, 10'd0);
      req[0] = 1'b1;
      pkt[0] = p1;
      tick();
      chk("t1_gnt_hi",  64'(gnt[0]), 64'd1);
      chk("t1_ev_lo",   64'(ev[0]),  64'd0);
      req[0] = 1'b0;
      tick();
      chk("t1_gnt_lo",  64'(gnt[0]),  64'd0);
      chk("t1_ev_hi",   64'(ev[0]),   64'd1);
      chk("t1_epkt",    64'(epkt[0]), 64'(p1));
      chk("t1_rxc",     64'(rxc[0]),  64'd1);
      chk("t1_lsrc",    64'(lsrc[0]), 64'd1);
      chk("t1_lpid",    64'(lpid[0]), 64'd1);
      chk("t1_seqerr",  64'(se[0]),   64'd0);
      tick();
      chk("t1_ev_pulse", 64'(ev[0]),  64'd0);

      // 2: held request yields one grant; next only after a low cycle
      req[0] = 1'b1;
      pkt[0] = mk(6'd1, 10'd2, 10'h2AA);
      gcnt   = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (gnt[0]) gcnt++;
      end
      chk("t2_one_grant", 64'(gcnt), 64'd1);
      chk("t2_rxc",       64'(rxc[0]), 64'd2);
      req[0] = 1'b0;
      tick();
      send(0, mk(6'd1, 10'd3, 10'h155), cap);
      chk("t2_rxc_after", 64'(rxc[0]), 64'd3);
      chk("t2_lpid",      64'(lpid[0]), 64'd3);
      chk("t2_sec",       64'(sec[0]), 64'd0);

      // 4: sequence gap from source 16, resync after the error
      send(0, mk(6'd16, 10'd1, 10'd7), cap);
      send(0, mk(6'd16, 10'd2, 10'd7), cap);
      chk("t4_sec_ok", 64'(sec[0]), 64'd0);
      send(0, mk(6'd16, 10'd4, 10'd7), cap);
      chk("t4_sec_gap",  64'(sec[0]), 64'd1);
      chk("t4_seqerr",   64'(se[0]),  64'd1);
      send(0, mk(6'd16, 10'd5, 10'd7), cap);
      chk("t4_sec_resync", 64'(sec[0]), 64'd1);
      chk("t4_lpid",       64'(lpid[0]), 64'd5);

      // 5: self-delivery error, then 1..1023 and 0 wrap with no error
      send(2, mk(6'd16, 10'd1, 10'd0), cap);
      chk("t5_self", 64'(sec[2]), 64'd1);
      for (int i = 1; i < 1024; i++) begin
         send(2, mk(6'd3, 10'(i), 10'(i)), cap);
      end
      send(2, mk(6'd3, 10'd0, 10'd0), cap);
      chk("t5_wrap_sec", 64'(sec[2]),  64'd1);
      chk("t5_rxc",      64'(rxc[2]),  64'd1025);
      chk("t5_lpid",     64'(lpid[2]), 64'd0);
      chk("t5_lsrc",     64'(lsrc[2]), 64'd3);

      // 3: fill a depth-4 FIFO with a 200-cycle drain, 5th waits for a pop
      p1 = mk(6'd5, 10'd1, 10'h011);
      send(1, p1, cap1);
      send(1, mk(6'd5, 10'd2, 10'h022), cap);
      send(1, mk(6'd5, 10'd3, 10'h033), cap);
      chk("t3_not_full", 64'(full[1]), 64'd0);
      send(1, mk(6'd5, 10'd4, 10'h044), cap);
      chk("t3_full", 64'(full[1]), 64'd1);
      req[1] = 1'b1;
      pkt[1] = mk(6'd5, 10'd5, 10'h055);
      cap5   = -1;
      n      = 0;
      while (cap5 < 0 && n < 400) begin
         tick();
         if (gnt[1]) cap5 = cyc;
         n++;
      end
      chk("t3_5th_latency", 64'(cap5 - cap1), 64'd202);
      chk("t3_rxc",         64'(rxc[1]),  64'd1);
      chk("t3_epkt",        64'(epkt[1]), 64'(p1));
      chk("t3_refull",      64'(full[1]), 64'd1);

      // 6: reset while Gnt is high with the queue loaded
      chk("t6_gnt_pre", 64'(gnt[1]), 64'd1);
      reset = 1'b0;
      #1;
      chk("t6_gnt",    64'(gnt[1]),  64'd0);
      chk("t6_full",   64'(full[1]), 64'd0);
      chk("t6_epkt",   64'(epkt[1]), 64'd0);
      chk("t6_rxc",    64'(rxc[1]),  64'd0);
      chk("t6_lsrc",   64'(lsrc[1]), 64'd0);
      chk("t6_lpid",   64'(lpid[1]), 64'd0);
      chk("t6_sec0",   64'(sec[0]),  64'd0);
      chk("t6_se0",    64'(se[0]),   64'd0);
      chk("t6_rxc2",   64'(rxc[2]),  64'd0);
      req[1] = 1'b0;
      #2 reset = 1'b1;
      tick();
      send(1, mk(6'd5, 10'd1, 10'h3FF), cap);
      n = 0;
      while (!ev[1] && n < 300) begin
         tick();
         n++;
      end
      chk("t6_pop_seen", 64'(ev[1]),   64'd1);
      chk("t6_sec1",     64'(sec[1]),  64'd0);
      chk("t6_rxc1",     64'(rxc[1]),  64'd1);
      chk("t6_lpid1",    64'(lpid[1]), 64'd1);
      send(0, mk(6'd16, 10'd1, 10'd0), cap);
      chk("t6_sec0_after", 64'(sec[0]), 64'd0);
      chk("t6_se0_after",  64'(se[0]),  64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
